// File: rtl/mem_arb_2p.sv
// rtl/mem_arb_2p.sv - two-master arbiter in front of a single-port valid/ready memory
// Define MEM_ARB_RR_EN for round-robin contention; default build is fixed priority (master 0).
module mem_arb_2p #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  r0_valid_i,
  input  logic                  r0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [WIDTH-1:0]      r0_wdata_i,
  input  logic                  r1_valid_i,
  input  logic                  r1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [WIDTH-1:0]      r1_wdata_i,
  output logic                  r0_ready_o,
  output logic [WIDTH-1:0]      r0_rdata_o,
  output logic                  r1_ready_o,
  output logic [WIDTH-1:0]      r1_rdata_o,
  output logic                  m_valid_o,
  output logic                  m_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WIDTH-1:0]      m_wdata_o,
  input  logic [WIDTH-1:0]      m_rdata_i,
  input  logic                  m_ready_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o
);

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   take;
  logic   win1;

  always_comb begin
    state_next = state;
    take       = 1'b0;
    win1       = 1'b0;
    case (state)
      IDLE: begin
        if (r0_valid_i || r1_valid_i) begin
          take       = 1'b1;
          // last_grant = 1 means master 1 went last, so master 0 wins round-robin contention
          win1       = (r0_valid_i && r1_valid_i) ? (RR_EN & ~last_grant) : r1_valid_i;
          state_next = GRANT;
        end
      end
      GRANT:   if (m_ready_i) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      m_valid_o  <= 1'b0;
      m_wr_rd_o  <= 1'b0;
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      r0_ready_o <= 1'b0;
      r1_ready_o <= 1'b0;
      r0_rdata_o <= '0;
      r1_rdata_o <= '0;
      grant_o    <= 2'b00;
    end else begin
      state      <= state_next;
      r0_ready_o <= 1'b0;
      r1_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            m_valid_o  <= 1'b1;
            m_wr_rd_o  <= win1 ? r1_wr_rd_i : r0_wr_rd_i;
            m_addr_o   <= win1 ? r1_addr_i  : r0_addr_i;
            m_wdata_o  <= win1 ? r1_wdata_i : r0_wdata_i;
            grant_o    <= win1 ? 2'b10 : 2'b01;
            last_grant <= win1;
          end
        end
        GRANT: begin
          if (m_ready_i) begin
            m_valid_o  <= 1'b0;
            r0_ready_o <= grant_o[0];
            r1_ready_o <= grant_o[1];
            if (!m_wr_rd_o) begin
              if (grant_o[0]) r0_rdata_o <= m_rdata_i;
              if (grant_o[1]) r1_rdata_o <= m_rdata_i;
            end
          end
        end
        RESP:    grant_o <= 2'b00;
        default: grant_o <= 2'b00;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_mem_arb_2p.sv
// tb/tb_mem_arb_2p.sv - directed vector bench for mem_arb_2p
module tb_mem_arb_2p;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_wr_rd, r1_valid, r1_wr_rd;
  logic [5:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_ready, r1_ready;
  logic [15:0] r0_rdata, r1_rdata;
  logic        m_valid, m_wr_rd, m_ready;
  logic [5:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  grant;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_arb_2p dut (
    .clk_i(clk), .rst_i(rst),
    .r0_valid_i(r0_valid), .r0_wr_rd_i(r0_wr_rd), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
    .r1_valid_i(r1_valid), .r1_wr_rd_i(r1_wr_rd), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
    .r0_ready_o(r0_ready), .r0_rdata_o(r0_rdata), .r1_ready_o(r1_ready), .r1_rdata_o(r1_rdata),
    .m_valid_o(m_valid), .m_wr_rd_o(m_wr_rd), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata), .m_ready_i(m_ready), .grant_o(grant), .busy_o(busy)
  );

  typedef struct {
    logic rst;
    logic r0v; logic r0w; logic [5:0] r0a; logic [15:0] r0d;
    logic r1v; logic r1w; logic [5:0] r1a; logic [15:0] r1d;
    logic mrdy; logic [15:0] mrd;
    logic e_mv; logic e_mw; logic [5:0] e_ma; logic [15:0] e_md;
    logic e_r0r; logic e_r1r; logic [15:0] e_r0d; logic [15:0] e_r1d;
    logic [1:0] e_g; logic e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; m_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g;

    rst = 1'b1;
    r0_valid = 1'b0; r0_wr_rd = 1'b0; r0_addr = 6'd0; r0_wdata = 16'h0;
    r1_valid = 1'b0; r1_wr_rd = 1'b0; r1_addr = 6'd0; r1_wdata = 16'h0;
    m_ready = 1'b0; m_rdata = 16'h0;

    // rst | r0 v,w,a,d | r1 v,w,a,d | m_ready, m_rdata | exp m_valid,m_wr_rd,m_addr,m_wdata | r0_ready,r1_ready,r0_rdata,r1_rdata | grant,busy
    vecs[0]  = '{1'b1, 1'b0,1'b0,6'd0,16'h0000,    1'b0,1'b0,6'd0,16'h0000, 1'b0,16'h0000, 1'b0,1'b0,6'd0,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 2'b00,1'b0};
    vecs[1]  = '{1'b0, 1'b1,1'b1,6'd5,16'hA5A5,    1'b0,1'b0,6'd0,16'h0000, 1'b0,16'h0000, 1'b1,1'b1,6'd5,16'hA5A5, 1'b0,1'b0,16'h0000,16'h0000, 2'b01,1'b1};
    vecs[2]  = '{1'b0, 1'b1,1'b1,6'd5,16'hA5A5,    1'b0,1'b0,6'd0,16'h0000, 1'b1,16'h0000, 1'b0,1'b1,6'd5,16'hA5A5, 1'b1,1'b0,16'h0000,16'h0000, 2'b01,1'b1};
    vecs[3]  = '{1'b0, 1'b1,1'b1,6'd5,16'hA5A5,    1'b0,1'b0,6'd0,16'h0000, 1'b0,16'h0000, 1'b0,1'b1,6'd5,16'hA5A5, 1'b0,1'b0,16'h0000,16'h0000, 2'b00,1'b0};
    vecs[4]  = '{1'b0, 1'b0,1'b0,6'd0,16'h0000,    1'b1,1'b0,6'd5,16'h1111, 1'b0,16'h0000, 1'b1,1'b0,6'd5,16'h1111, 1'b0,1'b0,16'h0000,16'h0000, 2'b10,1'b1};
    vecs[5]  = '{1'b0, 1'b0,1'b0,6'd0,16'h0000,    1'b1,1'b0,6'd5,16'h1111, 1'b1,16'hA5A5, 1'b0,1'b0,6'd5,16'h1111, 1'b0,1'b1,16'h0000,16'hA5A5, 2'b10,1'b1};
    vecs[6]  = '{1'b0, 1'b0,1'b0,6'd0,16'h0000,    1'b0,1'b0,6'd0,16'h0000, 1'b1,16'hFFFF, 1'b0,1'b0,6'd5,16'h1111, 1'b0,1'b0,16'h0000,16'hA5A5, 2'b00,1'b0};
    vecs[7]  = '{1'b0, 1'b0,1'b0,6'd0,16'h0000,    1'b0,1'b0,6'd0,16'h0000, 1'b1,16'hFFFF, 1'b0,1'b0,6'd5,16'h1111, 1'b0,1'b0,16'h0000,16'hA5A5, 2'b00,1'b0};
    vecs[8]  = '{1'b0, 1'b1,1'b0,6'd9,16'h2222,    1'b0,1'b0,6'd0,16'h0000, 1'b0,16'h0000, 1'b1,1'b0,6'd9,16'h2222, 1'b0,1'b0,16'h0000,16'hA5A5, 2'b01,1'b1};
    vecs[9]  = '{1'b0, 1'b1,1'b0,6'd9,16'h2222,    1'b0,1'b0,6'd0,16'h0000, 1'b1,16'h3C3C, 1'b0,1'b0,6'd9,16'h2222, 1'b1,1'b0,16'h3C3C,16'hA5A5, 2'b01,1'b1};
    vecs[10] = '{1'b0, 1'b0,1'b0,6'd0,16'h0000,    1'b0,1'b0,6'd0,16'h0000, 1'b0,16'h0000, 1'b0,1'b0,6'd9,16'h2222, 1'b0,1'b0,16'h3C3C,16'hA5A5, 2'b00,1'b0};

    #1;
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst;
      r0_valid = vecs[i].r0v; r0_wr_rd = vecs[i].r0w; r0_addr = vecs[i].r0a; r0_wdata = vecs[i].r0d;
      r1_valid = vecs[i].r1v; r1_wr_rd = vecs[i].r1w; r1_addr = vecs[i].r1a; r1_wdata = vecs[i].r1d;
      m_ready = vecs[i].mrdy; m_rdata = vecs[i].mrd;
      step();
      chk($sformatf("v%0d m_valid", i),  16'(m_valid),  16'(vecs[i].e_mv));
      chk($sformatf("v%0d m_wr_rd", i),  16'(m_wr_rd),  16'(vecs[i].e_mw));
      chk($sformatf("v%0d m_addr", i),   16'(m_addr),   16'(vecs[i].e_ma));
      chk($sformatf("v%0d m_wdata", i),  m_wdata,       vecs[i].e_md);
      chk($sformatf("v%0d r0_ready", i), 16'(r0_ready), 16'(vecs[i].e_r0r));
      chk($sformatf("v%0d r1_ready", i), 16'(r1_ready), 16'(vecs[i].e_r1r));
      chk($sformatf("v%0d r0_rdata", i), r0_rdata,      vecs[i].e_r0d);
      chk($sformatf("v%0d r1_rdata", i), r1_rdata,      vecs[i].e_r1d);
      chk($sformatf("v%0d grant", i),    16'(grant),    16'(vecs[i].e_g));
      chk($sformatf("v%0d busy", i),     16'(busy),     16'(vecs[i].e_busy));
    end

    // Contention: both masters request continuously for four transactions
    do_reset();
    r0_wr_rd = 1'b1; r0_addr = 6'd10; r0_wdata = 16'h0A0A;
    r1_wr_rd = 1'b1; r1_addr = 6'd20; r1_wdata = 16'h1B1B;
    r0_valid = 1'b1; r1_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      step();
      chk($sformatf("cont%0d grant", t),   16'(grant),   16'(exp_g));
      chk($sformatf("cont%0d m_addr", t),  16'(m_addr),  (exp_g == 2'b01) ? 16'd10 : 16'd20);
      m_ready = 1'b1;
      step();
      chk($sformatf("cont%0d r0_ready", t), 16'(r0_ready), 16'(exp_g[0]));
      chk($sformatf("cont%0d r1_ready", t), 16'(r1_ready), 16'(exp_g[1]));
      m_ready = 1'b0;
      step();
      chk($sformatf("cont%0d ready_drop", t), 16'({r1_ready, r0_ready}), 16'd0);
      chk($sformatf("cont%0d grant_idle", t), 16'(grant), 16'd0);
    end
    r0_valid = 1'b0;
    step();
    chk("cont_m1_after_drop grant", 16'(grant), 16'(2'b10));
    m_ready = 1'b1;
    step();
    chk("cont_m1_after_drop r1_ready", 16'(r1_ready), 16'd1);
    m_ready = 1'b0; r1_valid = 1'b0;
    step();

    // Slow memory: ready after 3 cycles, requester inputs wiggle during GRANT
    do_reset();
    r0_valid = 1'b1; r0_wr_rd = 1'b1; r0_addr = 6'd7; r0_wdata = 16'h0BEE;
    step();
    r0_wr_rd = 1'b0; r0_addr = 6'd3; r0_wdata = 16'hFFFF;
    r1_valid = 1'b1; r1_wr_rd = 1'b1; r1_addr = 6'd33; r1_wdata = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("slow%0d m_valid", c), 16'(m_valid), 16'd1);
      chk($sformatf("slow%0d m_addr", c),  16'(m_addr),  16'd7);
      chk($sformatf("slow%0d m_wdata", c), m_wdata,      16'h0BEE);
      chk($sformatf("slow%0d m_wr_rd", c), 16'(m_wr_rd), 16'd1);
      chk($sformatf("slow%0d grant", c),   16'(grant),   16'(2'b01));
      chk($sformatf("slow%0d r0_ready", c), 16'(r0_ready), 16'd0);
      if (c == 2) m_ready = 1'b1;
      step();
    end
    chk("slow r0_ready", 16'(r0_ready), 16'd1);
    chk("slow r1_ready", 16'(r1_ready), 16'd0);
    m_ready = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    chk("slow idle grant", 16'(grant), 16'd0);

    // Reset pulse while in GRANT drops the transaction
    do_reset();
    r0_valid = 1'b1; r0_wr_rd = 1'b0; r0_addr = 6'd2;
    step();
    chk("rst_grant pre m_valid", 16'(m_valid), 16'd1);
    rst = 1'b1;
    step();
    chk("rst_grant m_valid", 16'(m_valid), 16'd0);
    chk("rst_grant grant",   16'(grant),   16'd0);
    chk("rst_grant busy",    16'(busy),    16'd0);
    rst = 1'b0; r0_valid = 1'b0; m_ready = 1'b1;
    step();
    chk("rst_grant no r0_ready", 16'(r0_ready), 16'd0);
    m_ready = 1'b0;
    r1_valid = 1'b1; r1_wr_rd = 1'b1; r1_addr = 6'd4; r1_wdata = 16'h4444;
    step();
    chk("rst_next grant",  16'(grant),  16'(2'b10));
    chk("rst_next m_addr", 16'(m_addr), 16'd4);
    m_ready = 1'b1;
    step();
    chk("rst_next r1_ready", 16'(r1_ready), 16'd1);
    m_ready = 1'b0; r1_valid = 1'b0;
    step();
    chk("rst_next busy", 16'(busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arb_2p.md
# mem_arb_2p

Two-requester arbiter that shares the single-port valid/ready memory (WIDTH×DEPTH, `clk_i`/`rst_i`, `valid_i`/`wr_rd_i`/`addr_i`/`wdata_i` → `rdata_o`/`ready_o`) between two masters. It sits directly in front of the memory instance. It grants one complete transaction at a time, registers the winning request onto the memory port, and returns a one-cycle `ready` pulse plus read data to the winner. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
- `WIDTH`, 16: data width.
- `DEPTH`, 64: memory words.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `clk_i`  in  1: single clock; all logic on rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `r0_valid_i`, `r1_valid_i`  in  1: request from master 0 / 1; held until that master's `ready` pulse.
- `r0_wr_rd_i`, `r1_wr_rd_i`  in  1: 1 = write, 0 = read.
- `r0_addr_i`, `r1_addr_i`  in  ADDR_WIDTH: word address.
- `r0_wdata_i`, `r1_wdata_i`  in  WIDTH: write data.
- `r0_ready_o`, `r1_ready_o`  out  1: one-cycle completion pulse to master 0 / 1.
- `r0_rdata_o`, `r1_rdata_o`  out  WIDTH: read data, valid while the matching `ready` is high.
- `m_valid_o`, `m_wr_rd_o`  out  1: memory request and direction.
- `m_addr_o`  out  ADDR_WIDTH: memory address.
- `m_wdata_o`  out  WIDTH: memory write data.
- `m_rdata_i`  in  WIDTH: memory read data.
- `m_ready_i`  in  1: memory completion.
- `grant_o`  out  2: one-hot owner of the memory port; 00 when idle.
- `busy_o`  out  1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, GRANT, RESP.
- IDLE: sample `r0_valid_i`/`r1_valid_i`.
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: resolve per Configuration.
  - On grant: latch the winner's `wr_rd`/`addr`/`wdata` into the `m_*` registers, set `m_valid_o=1`, set `grant_o`, go to GRANT.
- GRANT: hold all `m_*` outputs stable.
  - The arbiter ignores the requester inputs in this state.
  - When `m_ready_i=1` is sampled: clear `m_valid_o`, capture `m_rdata_i` into the winner's `rdata` register (reads only; writes leave it unchanged), go to RESP.
- RESP: drive the winner's `rN_ready_o=1` for exactly one cycle, then go to IDLE.
  - `grant_o` stays set through RESP and clears on entry to IDLE.
  - The requester's `valid` is ignored during RESP, because its old request may still be visible that cycle.
- `rN_rdata_o` holds its last captured value until the next read completes for that master.
- `m_ready_i` is ignored in IDLE and RESP.
- `last_grant` register: updated on every grant; reset value selects master 1 as last, so master 0 wins the first contention.

## Timing
- Reset values: `m_valid_o=0`, `m_wr_rd_o=0`, `m_addr_o=0`, `m_wdata_o=0`, `r0_ready_o=0`, `r1_ready_o=0`, `r0_rdata_o=0`, `r1_rdata_o=0`, `grant_o=00`, `busy_o=0`, state IDLE, `last_grant=1`.
- Request sampled at edge k → `m_valid_o` high after edge k.
- `m_ready_i` sampled high at edge k+n (n≥1) → `rN_ready_o` high for the cycle after edge k+n → IDLE after edge k+n+1.
- Minimum 3 cycles per transaction; no pipelining or overlap.
- Back-to-back: a request sampled in the first IDLE cycle after RESP is granted at that edge, giving no dead cycle beyond IDLE.
- Reset asserted in any state returns to IDLE next edge. Any in-flight transaction is dropped with no ready pulse, and `m_valid_o` deasserts at that edge.
- The `m_*` outputs are registers only; there is no combinational path from `rN_*` to `m_*`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On contention, grant the master other than `last_grant`.
- Undefined: fixed priority. Master 0 always wins contention; `last_grant` is still maintained but unused for selection.
- Single-requester behaviour is identical in both builds.

## Test plan
- Master 0 writes 0xA5A5 to address 5, with the memory model asserting ready 1 cycle after valid → `m_addr_o=5`, `m_wdata_o=0xA5A5`, `m_wr_rd_o=1`; `r0_ready_o` pulses once at edge k+2; `r1_ready_o` stays 0.
- Master 1 reads address 5 after the write → `r1_rdata_o=0xA5A5` during the `r1_ready_o` pulse; `grant_o=10` throughout the transaction.
- With `MEM_ARB_RR_EN`, both masters hold continuous requests for 4 transactions → grant order 0,1,0,1; each `ready` pulse is exactly one cycle.
- Without the macro, the same stimulus → grant order 0,0,0,0; master 1 is served only after master 0 drops `valid`.
- Memory ready delayed 3 cycles → `m_*` outputs stable for all 3 cycles, changes on the requester inputs during GRANT are ignored, latency is 5 cycles.
- `rst_i` pulsed for 1 cycle while in GRANT → `m_valid_o=0` and `grant_o=00` after that edge, no `rN_ready_o` pulse, and the next request is served normally.
